// File: rtl/plic_ctx_scan.sv
// Per-context PLIC target selector: scans `lanes` sources per cycle, publishes the winner each pass,
// and runs the claim/complete handshake. Optional claim counter: define PLIC_CTX_CLAIM_CNT_EN.
module plic_ctx_scan #(
  parameter int irq_total  = 73,
  parameter int prio_width = 3,
  parameter int lanes      = 8
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  logic [irq_total-1:0]             i_pending,
  input  logic [irq_total-1:0]             i_enable,
  input  logic [irq_total*prio_width-1:0]  i_prio,
  input  logic [prio_width-1:0]            i_threshold,
  input  logic                             i_claim,
  input  logic                             i_complete,
  input  logic [9:0]                       i_complete_id,
  output logic                             o_ip,
  output logic [9:0]                       o_irq_id,
  output logic [prio_width-1:0]            o_irq_prio,
  output logic                             o_claim_valid,
  output logic [9:0]                       o_claim_id,
  output logic [irq_total-1:0]             o_in_service,
  output logic [31:0]                      o_claim_cnt
);

  localparam int NCHUNK = (irq_total + lanes - 1) / lanes;
  localparam int PAD    = NCHUNK * lanes;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  logic [PAD-1:0]              cand_pad;
  logic [PAD*prio_width-1:0]   prio_pad;
  logic [lanes-1:0]            lane_cand;
  logic [lanes*prio_width-1:0] lane_prio;
  logic [IDX_W-1:0]            idx;
  logic                        pub;
  logic [9:0]                  acc_id, win_id, chunk_id, merge_id, claim_id_nxt;
  logic [prio_width-1:0]       acc_prio, win_prio, chunk_prio, merge_prio;
  logic [irq_total-1:0]        in_service, svc_set, svc_clr;

  // Padding past irq_total keeps the last chunk's unused lanes as non-candidates.
  always_comb begin
    cand_pad = '0;
    prio_pad = '0;
    cand_pad[irq_total-1:0] = i_pending & i_enable & ~in_service;
    cand_pad[0] = 1'b0;
    prio_pad[irq_total*prio_width-1:0] = i_prio;
  end

  assign lane_cand = cand_pad[int'(idx) * lanes +: lanes];
  assign lane_prio = prio_pad[int'(idx) * lanes * prio_width +: lanes * prio_width];

  // Ascending scan with strict compare: ties resolve to the lowest id; prio 0 never wins.
  always_comb begin
    chunk_id   = '0;
    chunk_prio = '0;
    for (int j = 0; j < lanes; j++) begin
      if (lane_cand[j] && (lane_prio[j*prio_width +: prio_width] > chunk_prio)) begin
        chunk_prio = lane_prio[j*prio_width +: prio_width];
        chunk_id   = 10'(int'(idx) * lanes + j);
      end
    end
  end

  always_comb begin
    merge_id   = acc_id;
    merge_prio = acc_prio;
    if (chunk_prio > acc_prio) begin
      merge_id   = chunk_id;
      merge_prio = chunk_prio;
    end
  end

  assign claim_id_nxt = o_ip ? o_irq_id : 10'd0;

  // Claim set is applied after complete clear so a simultaneous pair leaves the bit set.
  always_comb begin
    svc_set = '0;
    svc_clr = '0;
    for (int k = 1; k < irq_total; k++) begin
      if (i_claim && (claim_id_nxt == 10'(k)))
        svc_set[k] = 1'b1;
      if (i_complete && (i_complete_id == 10'(k)))
        svc_clr[k] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      idx           <= '0;
      acc_id        <= '0;
      acc_prio      <= '0;
      win_id        <= '0;
      win_prio      <= '0;
      pub           <= 1'b0;
      o_ip          <= 1'b0;
      o_irq_id      <= '0;
      o_irq_prio    <= '0;
      o_claim_valid <= 1'b0;
      o_claim_id    <= '0;
      in_service    <= '0;
    end else begin
      o_claim_valid <= i_claim;
      o_claim_id    <= i_claim ? claim_id_nxt : 10'd0;
      in_service    <= (in_service & ~svc_clr) | svc_set;
      if (i_claim) begin
        o_ip       <= 1'b0;
        o_irq_id   <= '0;
        o_irq_prio <= '0;
        idx        <= '0;
        acc_id     <= '0;
        acc_prio   <= '0;
        pub        <= 1'b0;
      end else begin
        if (pub) begin
          o_irq_id   <= win_id;
          o_irq_prio <= win_prio;
          o_ip       <= (win_prio > i_threshold);
        end
        if (idx == LAST_IDX) begin
          win_id   <= merge_id;
          win_prio <= merge_prio;
          pub      <= 1'b1;
          acc_id   <= '0;
          acc_prio <= '0;
          idx      <= '0;
        end else begin
          acc_id   <= merge_id;
          acc_prio <= merge_prio;
          pub      <= 1'b0;
          idx      <= idx + 1'b1;
        end
      end
    end
  end

  assign o_in_service = in_service;

`ifdef PLIC_CTX_CLAIM_CNT_EN
  logic [31:0] claim_cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      claim_cnt <= '0;
    else if (i_claim && (claim_id_nxt != 10'd0))
      claim_cnt <= claim_cnt + 32'd1;
  end

  assign o_claim_cnt = claim_cnt;
`else
  assign o_claim_cnt = '0;
`endif

endmodule

// File: tb/tb_plic_ctx_scan.sv
// Self-checking bench for plic_ctx_scan: directed scenarios plus randomized passes
// compared against a whole-array winner model.
module tb_plic_ctx_scan;
  localparam int IRQ = 73;
  localparam int PW  = 3;
  localparam int LN  = 8;
  localparam int NCH = (IRQ + LN - 1) / LN;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic [IRQ-1:0]      i_pending = '0;
  logic [IRQ-1:0]      i_enable = '0;
  logic [IRQ*PW-1:0]   i_prio = '0;
  logic [PW-1:0]       i_threshold = '0;
  logic                i_claim = 1'b0;
  logic                i_complete = 1'b0;
  logic [9:0]          i_complete_id = '0;
  logic                o_ip;
  logic [9:0]          o_irq_id;
  logic [PW-1:0]       o_irq_prio;
  logic                o_claim_valid;
  logic [9:0]          o_claim_id;
  logic [IRQ-1:0]      o_in_service;
  logic [31:0]         o_claim_cnt;

  plic_ctx_scan #(.irq_total(IRQ), .prio_width(PW), .lanes(LN)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_pending(i_pending), .i_enable(i_enable),
    .i_prio(i_prio), .i_threshold(i_threshold), .i_claim(i_claim),
    .i_complete(i_complete), .i_complete_id(i_complete_id), .o_ip(o_ip),
    .o_irq_id(o_irq_id), .o_irq_prio(o_irq_prio), .o_claim_valid(o_claim_valid),
    .o_claim_id(o_claim_id), .o_in_service(o_in_service), .o_claim_cnt(o_claim_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit m_pend[IRQ];
  bit m_en[IRQ];
  bit m_svc[IRQ];
  int m_prio[IRQ];
  int m_thr = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2*NCH + 2) cyc();
  endtask

  task automatic drive();
    for (int k = 0; k < IRQ; k++) begin
      i_pending[k] = m_pend[k];
      i_enable[k]  = m_en[k];
      i_prio[k*PW +: PW] = PW'(m_prio[k]);
    end
    i_threshold = PW'(m_thr);
  endtask

  task automatic clear_model();
    for (int k = 0; k < IRQ; k++) begin
      m_pend[k] = 1'b0;
      m_en[k]   = 1'b0;
      m_prio[k] = 0;
    end
  endtask

  function automatic logic [IRQ-1:0] svc_vec();
    logic [IRQ-1:0] v;
    for (int k = 0; k < IRQ; k++) v[k] = m_svc[k];
    return v;
  endfunction

  // Whole-array reference: highest priority eligible source, lowest id on ties.
  task automatic model_win(output int id, output int pr);
    id = 0;
    pr = 0;
    for (int k = 1; k < IRQ; k++)
      if (m_pend[k] && m_en[k] && !m_svc[k] && m_prio[k] > pr) begin
        id = k;
        pr = m_prio[k];
      end
  endtask

  task automatic check_pub(input string tag);
    int id, pr;
    model_win(id, pr);
    check({tag, ".id"}, 128'(o_irq_id), 128'(id));
    check({tag, ".prio"}, 128'(o_irq_prio), 128'(pr));
    check({tag, ".ip"}, 128'(o_ip), 128'(pr > m_thr));
  endtask

  task automatic wait_id(input string tag, input int id, input int budget);
    int n = 0;
    while (o_irq_id != 10'(id) && n < budget) begin
      cyc();
      n++;
    end
    check(tag, 128'(o_irq_id), 128'(id));
  endtask

  // Claim assumes outputs are settled, or that o_ip is already known to be low.
  task automatic do_claim(input string tag, input bit with_complete, input int cid);
    int id, pr, e;
    model_win(id, pr);
    e = (o_ip === 1'b1) ? id : 0;
    i_claim = 1'b1;
    i_complete = with_complete;
    i_complete_id = 10'(cid);
    cyc();
    i_claim = 1'b0;
    i_complete = 1'b0;
    if (with_complete && cid > 0 && cid < IRQ) m_svc[cid] = 1'b0;
    if (e != 0) begin
      m_svc[e] = 1'b1;
`ifdef PLIC_CTX_CLAIM_CNT_EN
      exp_cnt++;
`endif
    end
    check({tag, ".valid"}, 128'(o_claim_valid), 128'(1));
    check({tag, ".cid"}, 128'(o_claim_id), 128'(e));
    check({tag, ".ipoff"}, 128'(o_ip), 128'(0));
    check({tag, ".svc"}, 128'(o_in_service), 128'(svc_vec()));
    check({tag, ".cnt"}, 128'(o_claim_cnt), 128'(exp_cnt));
  endtask

  task automatic do_complete(input string tag, input int cid);
    i_complete = 1'b1;
    i_complete_id = 10'(cid);
    cyc();
    i_complete = 1'b0;
    if (cid > 0 && cid < IRQ) m_svc[cid] = 1'b0;
    check({tag, ".svc"}, 128'(o_in_service), 128'(svc_vec()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ip"}, 128'(o_ip), 128'(0));
    check({tag, ".id"}, 128'(o_irq_id), 128'(0));
    check({tag, ".prio"}, 128'(o_irq_prio), 128'(0));
    check({tag, ".cv"}, 128'(o_claim_valid), 128'(0));
    check({tag, ".cid"}, 128'(o_claim_id), 128'(0));
    check({tag, ".svc"}, 128'(o_in_service), 128'(0));
    check({tag, ".cnt"}, 128'(o_claim_cnt), 128'(0));
  endtask

  initial begin
    int n, rid, id, pr;
    clear_model();
    for (int k = 0; k < IRQ; k++) m_svc[k] = 1'b0;
    drive();
    repeat (2) cyc();
    check_all_zero("reset");
    nrst = 1'b1;

    for (int c = 0; c < 40; c++) begin
      cyc();
      check("idle.ip", 128'(o_ip), 128'(0));
      check("idle.id", 128'(o_irq_id), 128'(0));
    end
    do_claim("claim0", 1'b0, 0);

    m_pend[5] = 1; m_en[5] = 1; m_prio[5] = 3;
    m_pend[70] = 1; m_en[70] = 1; m_prio[70] = 6;
    m_thr = 2;
    drive();
    wait_id("lat70", 70, 2*NCH + 1);
    check_pub("pub70");
    m_thr = 6;
    drive();
    settle();
    check_pub("thr6");

    clear_model();
    m_pend[12] = 1; m_en[12] = 1; m_prio[12] = 4;
    m_pend[40] = 1; m_en[40] = 1; m_prio[40] = 4;
    m_thr = 0;
    drive();
    settle();
    check_pub("tie12");
    m_en[12] = 0;
    drive();
    settle();
    check_pub("dis12");

    clear_model();
    m_pend[5] = 1; m_en[5] = 1; m_prio[5] = 3;
    m_pend[70] = 1; m_en[70] = 1; m_prio[70] = 6;
    m_thr = 2;
    drive();
    settle();
    check_pub("pre_claim");
    do_claim("claim70", 1'b0, 0);
    do_claim("claim_b2b", 1'b0, 0);
    settle();
    check_pub("repub5");
    do_complete("cmp70", 70);
    settle();
    check_pub("back70");

    do_claim("claim_cmp70", 1'b1, 70);
    do_complete("cmp_id0", 0);
    do_complete("cmp_id100", 100);
    do_complete("cmp_notsvc", 33);
    settle();
    check_pub("after_sim");

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < IRQ; k++) begin
        m_pend[k] = ($urandom_range(0, 3) == 0);
        m_en[k]   = ($urandom_range(0, 3) != 0);
        m_prio[k] = $urandom_range(0, (1 << PW) - 1);
      end
      m_thr = $urandom_range(0, 4);
      drive();
      settle();
      check_pub("rnd");
      if ($urandom_range(0, 2) == 0) begin
        do_claim("rnd_claim", 1'b0, 0);
        settle();
        check_pub("rnd_post");
      end
      if ($urandom_range(0, 1) == 0) begin
        rid = $urandom_range(0, 127);
        for (int k = 1; k < IRQ; k++)
          if (m_svc[k] && $urandom_range(0, 1) == 0) rid = k;
        do_complete("rnd_cmp", rid);
      end
    end

    // Mid-scan reset with a set in-service bit and (optionally) a nonzero counter.
    clear_model();
    m_pend[5] = 1; m_en[5] = 1; m_prio[5] = 3;
    m_pend[70] = 1; m_en[70] = 1; m_prio[70] = 6;
    m_thr = 2;
    drive();
    do_complete("pre_rst_cmp", 70);
    settle();
    do_claim("pre_rst_claim", 1'b0, 0);
    repeat (3) cyc();
    #2;
    nrst = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int k = 0; k < IRQ; k++) m_svc[k] = 1'b0;
    exp_cnt = 0;
    #2;
    nrst = 1'b1;
    n = 0;
    while (o_irq_id == 10'd0 && n < 3*NCH) begin
      cyc();
      n++;
    end
    check("rst_lat", 128'(n), 128'(NCH + 1));
    model_win(id, pr);
    check("rst_win", 128'(o_irq_id), 128'(id));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
